// File: rtl/matrix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_frame_sequencer
//
// Frame-playlist controller for the LED matrix. Walks the matrix's displayed
// frame buffer through COUNT equally spaced frames (FIRST + n*STRIDE) in the
// shared display RAM, holding each one for HOLD displayed frames. Every time
// the frame changes, the new byte address is written to the matrix
// MATRIX_ADDR_L / MATRIX_ADDR_H registers through a Wishbone master port.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   adr_i/dat_i/dat_o     Wishbone slave (CPU configuration), 16-byte window
//   we_i/stb_i/cyc_i      slave strobes; ack_o is registered, single cycle
//   m_adr_o/m_dat_o       Wishbone master towards the matrix control block
//   m_we_o/m_stb_o/m_cyc_o registered master strobes, m_ack_i master ack
//   frame_complete        level from the matrix; each rising edge = 1 frame
//   seq_irq               one-cycle pulse when the sequence wraps or ends
//
// Register map (offset from BASE_ADDRESS)
//   0 CTRL   bit0 run, bit1 loop, bit2 restart (write-1, reads 0)
//   1 STATUS bit0 busy, bit1 done (read only)
//   2 INDEX  current frame index (read only)
//   3 COUNT  4 HOLD  5/6 FIRST_L/H  7/8 STRIDE_L/H   9..15 read 0
// -----------------------------------------------------------------------------
module matrix_frame_sequencer #(
    parameter int          ADDRESS_WIDTH         = 16,
    parameter int          DATA_WIDTH            = 8,
    parameter logic [15:0] BASE_ADDRESS          = 16'h0010,
    parameter logic [15:0] MATRIX_BASE           = 16'h0000,
    parameter logic [15:0] DEFAULT_FRAME_ADDRESS = 16'h4000,
    parameter logic [15:0] MATRIX_ADDR_L         = 16'h0004,
    parameter logic [15:0] MATRIX_ADDR_H         = 16'h0005
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic                     we_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    output logic                     ack_o,
    output logic [ADDRESS_WIDTH-1:0] m_adr_o,
    output logic [DATA_WIDTH-1:0]    m_dat_o,
    output logic                     m_we_o,
    output logic                     m_stb_o,
    output logic                     m_cyc_o,
    input  logic                     m_ack_i,
    input  logic                     frame_complete,
    output logic                     seq_irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_L = 2'd1,
        ST_WR_H = 2'd2
    } state_t;

    // Configuration registers
    logic        run_q,      run_d;
    logic        loop_q,     loop_d;
    logic        done_q,     done_d;
    logic [7:0]  count_q,    count_d;
    logic [7:0]  hold_q,     hold_d;
    logic [15:0] first_q,    first_d;
    logic [15:0] stride_q,   stride_d;

    // Sequencer state
    logic [7:0]  index_q,    index_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic        pending_q,  pending_d;
    logic        fc_q,       fc_d;
    logic        irq_q,      irq_d;
    logic        ack_q,      ack_d;

    // Master port
    state_t      state_q,    state_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [15:0] m_adr_q,    m_adr_d;
    logic [7:0]  m_dat_q,    m_dat_d;
    logic        m_we_q,     m_we_d;
    logic        m_stb_q,    m_stb_d;
    logic        m_cyc_q,    m_cyc_d;

    logic        sel;
    logic        wr_en;
    logic        fc_rise;
    logic        start;
    logic [7:0]  eff_count;
    logic [7:0]  eff_hold;
    logic [8:0]  hold_inc;
    logic [8:0]  index_inc;

    assign sel       = cyc_i & stb_i & ((adr_i & 16'hFFF0) == BASE_ADDRESS);
    // Side effects happen on the same edge that raises ack_o.
    assign wr_en     = sel & we_i & ~ack_q;
    assign fc_rise   = frame_complete & ~fc_q;
    // A zero COUNT or HOLD behaves like 1.
    assign eff_count = (count_q == 8'd0) ? 8'd1 : count_q;
    assign eff_hold  = (hold_q  == 8'd0) ? 8'd1 : hold_q;
    assign hold_inc  = {1'b0, hold_cnt_q} + 9'd1;
    assign index_inc = {1'b0, index_q} + 9'd1;

    always_comb begin
        run_d      = run_q;
        loop_d     = loop_q;
        done_d     = done_q;
        count_d    = count_q;
        hold_d     = hold_q;
        first_d    = first_q;
        stride_d   = stride_q;
        index_d    = index_q;
        hold_cnt_d = hold_cnt_q;
        cur_addr_d = cur_addr_q;
        pending_d  = pending_q;
        fc_d       = frame_complete;
        irq_d      = 1'b0;
        ack_d      = sel & ~ack_q;
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        m_adr_d    = m_adr_q;
        m_dat_d    = m_dat_q;
        m_we_d     = m_we_q;
        m_stb_d    = m_stb_q;
        m_cyc_d    = m_cyc_q;
        start      = 1'b0;

        // CPU register writes
        if (wr_en) begin
            case (adr_i[3:0])
                4'd0: begin
                    run_d  = dat_i[0];
                    loop_d = dat_i[1];
                    // Rising run, or restart while staying in run.
                    start  = dat_i[0] & (~run_q | dat_i[2]);
                end
                4'd3:    count_d         = dat_i;
                4'd4:    hold_d          = dat_i;
                4'd5:    first_d[7:0]    = dat_i;
                4'd6:    first_d[15:8]   = dat_i;
                4'd7:    stride_d[7:0]   = dat_i;
                4'd8:    stride_d[15:8]  = dat_i;
                default: ;
            endcase
        end

        // Master write FSM. Pending is consumed here and may be re-set
        // below by an advance in the same cycle, so set always wins.
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d   = ST_WR_L;
                    wr_addr_d = cur_addr_q;
                    pending_d = 1'b0;
                    m_cyc_d   = 1'b1;
                    m_stb_d   = 1'b1;
                    m_we_d    = 1'b1;
                    m_adr_d   = MATRIX_BASE + MATRIX_ADDR_L;
                    m_dat_d   = cur_addr_q[7:0];
                end
            end
            ST_WR_L: begin
                if (m_ack_i) begin
                    state_d = ST_WR_H;
                    m_adr_d = MATRIX_BASE + MATRIX_ADDR_H;
                    // High byte comes from the same snapshot as the low byte.
                    m_dat_d = wr_addr_q[15:8];
                end
            end
            ST_WR_H: begin
                if (m_ack_i) begin
                    state_d = ST_IDLE;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    m_adr_d = 16'h0000;
                    m_dat_d = 8'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                m_cyc_d = 1'b0;
                m_stb_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase

        // Sequencing; a start/restart swallows a coincident frame edge.
        if (start) begin
            index_d    = 8'd0;
            cur_addr_d = first_q;
            hold_cnt_d = 8'd0;
            done_d     = 1'b0;
            pending_d  = 1'b1;
        end else if (fc_rise && run_q) begin
            if (hold_inc >= {1'b0, eff_hold}) begin
                hold_cnt_d = 8'd0;
                if (index_inc < {1'b0, eff_count}) begin
                    index_d    = index_inc[7:0];
                    cur_addr_d = cur_addr_q + stride_q;
                    pending_d  = 1'b1;
                end else if (loop_q) begin
                    index_d    = 8'd0;
                    cur_addr_d = first_q;
                    pending_d  = 1'b1;
                    irq_d      = 1'b1;
                end else begin
                    // End of a one-shot sequence: the last frame stays up.
                    run_d  = 1'b0;
                    done_d = 1'b1;
                    irq_d  = 1'b1;
                end
            end else begin
                hold_cnt_d = hold_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q      <= 1'b0;
            loop_q     <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= 8'd1;
            hold_q     <= 8'd1;
            first_q    <= DEFAULT_FRAME_ADDRESS;
            stride_q   <= 16'h0400;
            index_q    <= 8'd0;
            hold_cnt_q <= 8'd0;
            cur_addr_q <= DEFAULT_FRAME_ADDRESS;
            pending_q  <= 1'b0;
            fc_q       <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            state_q    <= ST_IDLE;
            wr_addr_q  <= 16'h0000;
            m_adr_q    <= 16'h0000;
            m_dat_q    <= 8'h00;
            m_we_q     <= 1'b0;
            m_stb_q    <= 1'b0;
            m_cyc_q    <= 1'b0;
        end else begin
            run_q      <= run_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            first_q    <= first_d;
            stride_q   <= stride_d;
            index_q    <= index_d;
            hold_cnt_q <= hold_cnt_d;
            cur_addr_q <= cur_addr_d;
            pending_q  <= pending_d;
            fc_q       <= fc_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            m_adr_q    <= m_adr_d;
            m_dat_q    <= m_dat_d;
            m_we_q     <= m_we_d;
            m_stb_q    <= m_stb_d;
            m_cyc_q    <= m_cyc_d;
        end
    end

    // Slave read mux, zero whenever this block is not addressed.
    always_comb begin
        dat_o = '0;
        if (sel) begin
            case (adr_i[3:0])
                4'd0:    dat_o = {6'b0, loop_q, run_q};
                4'd1:    dat_o = {6'b0, done_q, (state_q != ST_IDLE)};
                4'd2:    dat_o = index_q;
                4'd3:    dat_o = count_q;
                4'd4:    dat_o = hold_q;
                4'd5:    dat_o = first_q[7:0];
                4'd6:    dat_o = first_q[15:8];
                4'd7:    dat_o = stride_q[7:0];
                4'd8:    dat_o = stride_q[15:8];
                default: dat_o = '0;
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign seq_irq = irq_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_we_o  = m_we_q;
    assign m_stb_o = m_stb_q;
    assign m_cyc_o = m_cyc_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_frame_sequencer
//
// Directed and randomised playlists. The expected list of frame addresses is
// computed as FIRST + (frame number mod COUNT) * STRIDE and compared with the
// L/H pairs captured on the master port by a randomly stalling responder.
// -----------------------------------------------------------------------------
module tb_matrix_frame_sequencer;

    localparam logic [15:0] BASE  = 16'h0010;
    localparam logic [15:0] MBASE = 16'h0200;
    localparam logic [15:0] DEFF  = 16'h4000;
    localparam logic [15:0] ML    = 16'h0004;
    localparam logic [15:0] MH    = 16'h0005;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] adr_i = '0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic        ack_o;
    logic [15:0] m_adr_o;
    logic [7:0]  m_dat_o;
    logic        m_we_o, m_stb_o, m_cyc_o;
    logic        m_ack_i = 1'b0;
    logic        frame_complete = 1'b0;
    logic        seq_irq;

    int          tests = 0;
    int          fails = 0;
    int          irq_cnt = 0;
    bit          stall = 1'b0;
    logic [15:0] mon_adr[$];
    logic [7:0]  mon_dat[$];

    matrix_frame_sequencer #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDRESS(BASE),
        .MATRIX_BASE(MBASE), .DEFAULT_FRAME_ADDRESS(DEFF),
        .MATRIX_ADDR_L(ML), .MATRIX_ADDR_H(MH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i),
        .dat_o(dat_o), .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i),
        .ack_o(ack_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
        .m_ack_i(m_ack_i), .frame_complete(frame_complete), .seq_irq(seq_irq)
    );

    always #5 clk_i = ~clk_i;

    // Matrix-side responder: random 0..2 wait states, records every accepted write.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            m_ack_i = 1'b0;
            if (m_cyc_o && m_stb_o && m_we_o && !stall && !rst_i) begin
                if (wait_cnt == 0) begin
                    m_ack_i = 1'b1;
                    mon_adr.push_back(m_adr_o);
                    mon_dat.push_back(m_dat_o);
                    wait_cnt = $urandom_range(0, 2);
                end else begin
                    wait_cnt--;
                end
            end
            if (seq_irq) irq_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [3:0] off, input logic [7:0] d);
        int n;
        @(negedge clk_i);
        adr_i = BASE + {12'h000, off}; dat_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!ack_o && n < 10);
        check("wb_write_ack", {31'd0, ack_o}, 32'd1);
        we_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] off, output logic [7:0] d);
        int n;
        @(negedge clk_i);
        adr_i = BASE + {12'h000, off}; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk_i); n++; end while (!ack_o && n < 10);
        if (!ack_o) check("wb_read_ack", {31'd0, ack_o}, 32'd1);
        d = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] off, input logic [7:0] exp);
        logic [7:0] d;
        wb_read(off, d);
        $display("[TB] read  %-10s off=%0d data=%02h expect=%02h", tag, off, d, exp);
        check(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic pulse_fc();
        @(negedge clk_i); frame_complete = 1'b1;
        repeat (3) @(negedge clk_i);
        frame_complete = 1'b0;
        repeat (25) @(negedge clk_i);
    endtask

    task automatic clear_mon();
        mon_adr.delete();
        mon_dat.delete();
        irq_cnt = 0;
    endtask

    // Compare captured L/H pairs against a list of expected frame addresses.
    task automatic check_writes(input string tag, input logic [15:0] exp[$]);
        check({tag, "_nwr"}, mon_adr.size(), 2 * exp.size());
        for (int i = 0; i < exp.size() && 2 * i + 1 < mon_adr.size(); i++) begin
            $display("[TB] write %-10s #%0d L@%04h=%02h H@%04h=%02h expect %04h", tag, i,
                     mon_adr[2*i], mon_dat[2*i], mon_adr[2*i+1], mon_dat[2*i+1], exp[i]);
            check({tag, "_adrL"}, {16'd0, mon_adr[2*i]}, {16'd0, MBASE + ML});
            check({tag, "_adrH"}, {16'd0, mon_adr[2*i+1]}, {16'd0, MBASE + MH});
            check({tag, "_addr"}, {16'd0, mon_dat[2*i+1], mon_dat[2*i]}, {16'd0, exp[i]});
        end
    endtask

    // Program a playlist, start it, feed n_edges frame edges and check the
    // result against a straightforward arithmetic model of the playlist.
    task automatic run_scenario(input string tag, input logic [15:0] first,
                                input logic [15:0] stride, input logic [7:0] count,
                                input logic [7:0] hold, input bit loop, input int n_edges);
        logic [15:0] exp[$];
        int ec, eh, hc, adv, idx, irqs;
        bit running, done;
        logic [31:0] a;
        wb_write(4'd0, {6'd0, loop, 1'b0});
        repeat (20) @(negedge clk_i);
        wb_write(4'd3, count);
        wb_write(4'd4, hold);
        wb_write(4'd5, first[7:0]);
        wb_write(4'd6, first[15:8]);
        wb_write(4'd7, stride[7:0]);
        wb_write(4'd8, stride[15:8]);
        clear_mon();
        wb_write(4'd0, {6'd0, loop, 1'b1});
        repeat (20) @(negedge clk_i);

        ec = (count == 0) ? 1 : int'(count);
        eh = (hold == 0) ? 1 : int'(hold);
        hc = 0; adv = 0; idx = 0; irqs = 0; running = 1'b1; done = 1'b0;
        exp.push_back(first);
        for (int e = 0; e < n_edges; e++) begin
            pulse_fc();
            if (running) begin
                hc++;
                if (hc == eh) begin
                    hc = 0;
                    adv++;
                    if (loop || adv < ec) begin
                        idx = adv % ec;
                        a = {16'd0, first} + idx * {16'd0, stride};
                        exp.push_back(a[15:0]);
                        if (idx == 0) irqs++;
                    end else begin
                        running = 1'b0;
                        done = 1'b1;
                        irqs++;
                    end
                end
            end
        end
        repeat (10) @(negedge clk_i);
        $display("[TB] scen  %-10s first=%04h stride=%04h count=%0d hold=%0d loop=%0d edges=%0d",
                 tag, first, stride, count, hold, loop, n_edges);
        check_writes(tag, exp);
        check({tag, "_irq"}, irq_cnt, irqs);
        read_check({tag, "_index"}, 4'd2, idx[7:0]);
        read_check({tag, "_status"}, 4'd1, {6'd0, done, 1'b0});
        read_check({tag, "_ctrl"}, 4'd0, {6'd0, loop, running});
    endtask

    initial begin
        logic [15:0] exp[$];
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_m_cyc", {31'd0, m_cyc_o}, 0);
        check("rst_m_stb", {31'd0, m_stb_o}, 0);
        check("rst_m_we",  {31'd0, m_we_o}, 0);
        check("rst_m_adr", {16'd0, m_adr_o}, 0);
        check("rst_m_dat", {24'd0, m_dat_o}, 0);
        check("rst_ack",   {31'd0, ack_o}, 0);
        check("rst_irq",   {31'd0, seq_irq}, 0);
        check("rst_dat_o", {24'd0, dat_o}, 0);
        read_check("ctrl",     4'd0, 8'h02);
        read_check("status",   4'd1, 8'h00);
        read_check("index",    4'd2, 8'h00);
        read_check("count",    4'd3, 8'h01);
        read_check("hold",     4'd4, 8'h01);
        read_check("first_l",  4'd5, DEFF[7:0]);
        read_check("first_h",  4'd6, DEFF[15:8]);
        read_check("stride_l", 4'd7, 8'h00);
        read_check("stride_h", 4'd8, 8'h04);
        wb_write(4'd12, 8'hA5);
        read_check("reg12",    4'd12, 8'h00);

        // ---------------- directed playlists ----------------
        run_scenario("loop",   16'h8000, 16'h0400, 8'd3, 8'd2, 1'b1, 6);
        run_scenario("oneshot", 16'h8000, 16'h0400, 8'd3, 8'd2, 1'b0, 8);
        run_scenario("wrap16", 16'hC000, 16'h4000, 8'd2, 8'd1, 1'b1, 2);

        // ---------------- stalled master, two advances ----------------
        wb_write(4'd0, 8'h02);
        repeat (20) @(negedge clk_i);
        wb_write(4'd3, 8'd3);
        wb_write(4'd4, 8'd1);
        wb_write(4'd5, 8'h00);
        wb_write(4'd6, 8'h80);
        wb_write(4'd7, 8'h00);
        wb_write(4'd8, 8'h04);
        clear_mon();
        stall = 1'b1;
        wb_write(4'd0, 8'h03);
        repeat (5) @(negedge clk_i);
        check("stall_stb", {31'd0, m_stb_o}, 1);
        check("stall_adr", {16'd0, m_adr_o}, {16'd0, MBASE + ML});
        check("stall_dat", {24'd0, m_dat_o}, 32'h00);
        read_check("stall_busy", 4'd1, 8'h01);
        pulse_fc();
        pulse_fc();
        stall = 1'b0;
        repeat (30) @(negedge clk_i);
        exp.delete();
        exp.push_back(16'h8000);
        exp.push_back(16'h8800);
        check_writes("stall", exp);
        read_check("stall_idx", 4'd2, 8'd2);

        // ---------------- restart while running ----------------
        clear_mon();
        wb_write(4'd0, 8'h07);
        repeat (20) @(negedge clk_i);
        exp.delete();
        exp.push_back(16'h8000);
        check_writes("restart", exp);
        read_check("restart_idx", 4'd2, 8'd0);

        // ---------------- restart while stopped is ignored ----------------
        pulse_fc();
        wb_write(4'd0, 8'h02);
        repeat (20) @(negedge clk_i);
        clear_mon();
        wb_write(4'd0, 8'h06);
        repeat (20) @(negedge clk_i);
        exp.delete();
        check_writes("rst_off", exp);
        read_check("rst_off_idx", 4'd2, 8'd1);
        read_check("rst_off_ctrl", 4'd0, 8'h02);

        // ---------------- randomised playlists ----------------
        for (int k = 0; k < 6; k++) begin
            run_scenario($sformatf("rand%0d", k), 16'($urandom), 16'($urandom),
                         8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), $urandom_range(0, 9));
        end

        // ---------------- asynchronous reset mid-write ----------------
        wb_write(4'd0, 8'h02);
        repeat (20) @(negedge clk_i);
        stall = 1'b1;
        wb_write(4'd0, 8'h03);
        n = 0;
        while (!m_stb_o && n < 10) begin @(negedge clk_i); n++; end
        check("arst_pre_stb", {31'd0, m_stb_o}, 1);
        pulse_fc();
        rst_i = 1'b1;
        #1;
        check("arst_cyc", {31'd0, m_cyc_o}, 0);
        check("arst_stb", {31'd0, m_stb_o}, 0);
        check("arst_we",  {31'd0, m_we_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        stall = 1'b0;
        read_check("arst_index", 4'd2, 8'd0);
        read_check("arst_ctrl",  4'd0, 8'h02);
        read_check("arst_first", 4'd6, DEFF[15:8]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_frame_sequencer.md
# matrix_frame_sequencer

Frame-playlist controller for the LED matrix block. Steps the matrix's displayed frame buffer through a sequence of equally spaced frames in the shared display RAM, holding each frame for a programmable number of display frames. It is a Wishbone slave for CPU configuration and a Wishbone master that rewrites the matrix `MATRIX_ADDR_L`/`MATRIX_ADDR_H` registers in step with the matrix `frame_complete` output.

## Interface
- `ADDRESS_WIDTH`, 16, Wishbone address width (slave and master)
- `DATA_WIDTH`, 8, Wishbone data width
- `BASE_ADDRESS`, 'h0010, slave register window base; 16-byte window, match on `(adr_i & 16'hFFF0)`
- `MATRIX_BASE`, 'h0000, base address of the matrix control register block

Ports:
- `clk_i` in 1: system clock; one clock domain
- `rst_i` in 1: reset, asynchronous, active-high
- `adr_i` in 16: slave address
- `dat_i` in 8: slave write data
- `dat_o` out 8: slave read data, combinational, 0 when not selected
- `we_i`, `stb_i`, `cyc_i` in 1: slave strobes
- `ack_o` out 1: slave ack, registered
- `m_adr_o` out 16: master address
- `m_dat_o` out 8: master write data
- `m_we_o`, `m_stb_o`, `m_cyc_o` out 1: master strobes, registered
- `m_ack_i` in 1: master ack
- `frame_complete` in 1: level from matrix; rising edge = one displayed frame
- `seq_irq` out 1: one-cycle pulse on sequence wrap or end

## Operation
- Register map (offset from `BASE_ADDRESS`):
  - 0 CTRL: bit0 run, bit1 loop, bit2 restart (write-1, reads 0)
  - 1 STATUS (RO): bit0 busy (master FSM not IDLE), bit1 done
  - 2 INDEX (RO): current frame index
  - 3 COUNT: frames in sequence; 0 is treated as 1
  - 4 HOLD: displayed frames per image; 0 is treated as 1
  - 5/6 FIRST_L/H: byte address of frame 0
  - 7/8 STRIDE_L/H: byte distance between frames
  - 9–15: read 0, writes ignored, still acked
- Reset values: run 0, loop 1, done 0, INDEX 0, COUNT 1, HOLD 1, FIRST = `DEFAULT_FRAME_ADDRESS`, STRIDE 'h0400, all master outputs 0, `ack_o` 0, `seq_irq` 0.
- Start and restart:
  - Run 0→1, or a restart write while run = 1: INDEX←0, cur_addr←FIRST, hold_cnt←0, done←0, pending←1.
  - Restart while run = 0 is ignored.
  - Clearing run stops advancing. A write already in flight completes.
- Advance, on a `frame_complete` rising edge (registered edge detect) with run = 1:
  - hold_cnt increments. When it reaches effective HOLD, hold_cnt←0 and the frame advances.
  - If INDEX < COUNT−1: INDEX+1, cur_addr←cur_addr+STRIDE (16-bit, wraps mod 2^16), pending←1.
  - If INDEX = COUNT−1 and loop = 1: INDEX←0, cur_addr←FIRST, pending←1, `seq_irq` pulses.
  - If INDEX = COUNT−1 and loop = 0: run←0, done←1, `seq_irq` pulses, no write; the last frame stays displayed.
- Master FSM IDLE→WR_L→WR_H→IDLE:
  - In IDLE with pending = 1: wr_addr←cur_addr, pending←0, enter WR_L.
  - WR_L drives cyc/stb/we = 1, `m_adr_o` = MATRIX_BASE+`MATRIX_ADDR_L`, `m_dat_o` = wr_addr[7:0].
  - WR_H drives `m_adr_o` = MATRIX_BASE+`MATRIX_ADDR_H`, `m_dat_o` = wr_addr[15:8].
  - Each state holds until `m_ack_i`. cyc/stb drop for one IDLE cycle between transactions. There is no timeout.
  - L and H always come from the same wr_addr snapshot. An advance during a write updates cur_addr and sets pending; only the newest address is written next.
- CPU writes to COUNT/HOLD/FIRST/STRIDE take effect at the next advance or restart.

## Timing
- Slave: `ack_o` <= cyc_i & stb_i & in_range & ~ack_o. Ack comes one cycle after strobe, single-cycle.
- Register write side effects occur on the acking edge.
- Advance latency: the edge detect registers `frame_complete`. Pending sets on the cycle after the rising edge is registered.
- Master write latency: WR_L asserts `m_stb_o` on the cycle after pending is seen in IDLE.
- With zero-wait ack, the full L+H update takes 4 cycles: WR_L, WR_H, IDLE, plus the entry cycle.
- Simultaneous restart write and `frame_complete` edge: restart wins, and the edge is not counted.
- Asynchronous reset mid-transaction: `m_cyc_o`/`m_stb_o` drop immediately and all state returns to reset values.

## Test plan
- Reset, then read all registers → CTRL = 0x02, COUNT = 1, HOLD = 1, STRIDE = 0x0400, FIRST = `DEFAULT_FRAME_ADDRESS`, all master outputs 0.
- FIRST = 0x8000, STRIDE = 0x0400, COUNT = 3, HOLD = 2, loop = 1, run → writes of 0x8000 on start; after every 2 `frame_complete` edges, writes 0x8400, then 0x8800, then 0x8000. `seq_irq` pulses at the wrap.
- Same setup with loop = 0 → after 0x8800 and 2 more edges: run = 0, done = 1, one `seq_irq`, no further master writes.
- Stall `m_ack_i` 50 cycles during WR_L while 2 advances occur (HOLD = 1) → completes 0x8000 L/H, then exactly one L/H pair with 0x8800. No torn L/H pair.
- STRIDE = 0x4000, FIRST = 0xC000, COUNT = 2 → second address 0x0000 (wrap).
- Assert `rst_i` while `m_stb_o` = 1 → `m_cyc_o`/`m_stb_o` = 0 in the same cycle; INDEX = 0 after release.
